// File: rtl/dma_channel_scheduler.sv
// dma_channel_scheduler: round-robin slicer that shares one AXI4 transfer
// engine among DMA channels. Each armed channel is served in slices of at
// most C_FRAME_SIZE bytes, rotating fairly, until its byte count drains.
module dma_channel_scheduler #(
    parameter int C_NUM_CHANNELS           = 4,
    parameter int C_TRANSACTION_SIZE_WIDTH = 32,
    parameter int C_FRAME_SIZE             = 256,
    localparam int CW = $clog2(C_NUM_CHANNELS) + 1
) (
    input  logic                                         ACLK,
    input  logic                                         ARESET,
    input  logic [C_NUM_CHANNELS-1:0]                    ch_start,
    input  logic [C_NUM_CHANNELS*C_TRANSACTION_SIZE_WIDTH-1:0] ch_size,
    output logic                                         grant_valid,
    input  logic                                         grant_ready,
    output logic [CW-1:0]                                grant_channel,
    output logic [C_TRANSACTION_SIZE_WIDTH-1:0]          grant_length,
    input  logic                                         slice_done,
    output logic [C_NUM_CHANNELS-1:0]                    ch_done,
    output logic [C_NUM_CHANNELS-1:0]                    ch_active,
    output logic                                         busy
);

    localparam int N = C_NUM_CHANNELS;
    localparam int W = C_TRANSACTION_SIZE_WIDTH;
    localparam logic [W-1:0] FRAME = W'(C_FRAME_SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_OFFER = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [W-1:0]  r_rem [N];
    logic [CW-1:0] r_last;
    logic [CW-1:0] r_gch;
    logic [W-1:0]  r_glen;
    logic [N-1:0]  r_done;

    logic [N-1:0]  w_active;
    logic          w_any;
    logic [CW-1:0] w_pick;
    logic          w_pick_vld;
    logic [W-1:0]  w_pick_rem;
    logic [W-1:0]  w_pick_len;
    logic          w_hs;
    logic          w_sd;
    logic [N-1:0]  w_done_set;

    // Handshake and completion are only honoured in their own states.
    assign w_hs = (r_state == S_OFFER) && grant_ready;
    assign w_sd = (r_state == S_RUN) && slice_done;

    // Per-channel activity flags and slice-completion detection.
    always_comb begin
        w_active   = '0;
        w_done_set = '0;
        for (int i = 0; i < N; i++) begin
            w_active[i] = (r_rem[i] != '0);
            if (w_sd && (r_gch == CW'(i)) && (r_rem[i] == r_glen)) begin
                w_done_set[i] = 1'b1;
            end
        end
    end

    assign w_any = |w_active;

    // Round-robin pick: first active channel after r_last, r_last itself last.
    always_comb begin
        int idx;
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_pick_rem = '0;
        idx        = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(r_last) + k) % N;
            if (!w_pick_vld && w_active[idx]) begin
                w_pick     = CW'(idx);
                w_pick_vld = 1'b1;
                w_pick_rem = r_rem[idx];
            end
        end
    end

    assign w_pick_len = (w_pick_rem > FRAME) ? FRAME : w_pick_rem;

    // FSM state register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_ARB;
            S_ARB:   w_next = w_pick_vld ? S_OFFER : S_IDLE;
            S_OFFER: if (w_hs) w_next = S_RUN;
            S_RUN:   if (w_sd) w_next = S_ARB;
            default: w_next = S_IDLE;
        endcase
    end

    // Remaining-byte counters: slice retirement on the granted channel, arming elsewhere.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < N; i++) begin
                r_rem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_sd && (r_gch == CW'(i))) begin
                    r_rem[i] <= r_rem[i] - r_glen;
                end else if (ch_start[i] && (ch_size[i*W +: W] != '0) && (r_rem[i] == '0)) begin
                    r_rem[i] <= ch_size[i*W +: W];
                end
            end
        end
    end

    // Grant latch in ARB, rotation pointer on handshake, one-cycle done pulses.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_gch  <= '0;
            r_glen <= '0;
            r_last <= CW'(N - 1);
            r_done <= '0;
        end else begin
            r_done <= w_done_set;
            if ((r_state == S_ARB) && w_pick_vld) begin
                r_gch  <= w_pick;
                r_glen <= w_pick_len;
            end
            if (w_hs) begin
                r_last <= r_gch;
            end
        end
    end

    assign grant_valid   = (r_state == S_OFFER);
    assign grant_channel = r_gch;
    assign grant_length  = r_glen;
    assign ch_done       = r_done;
    assign ch_active     = w_active;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: doc/dma_channel_scheduler.md
# dma_channel_scheduler

Sequential round-robin scheduler that shares the single AXI4 transfer engine between the DMA channels. Each channel is armed with a transfer size in bytes. The scheduler then hands the engine one slice at a time, of at most `C_FRAME_SIZE` bytes, rotating fairly among the armed channels. It tracks each channel's remaining byte count and signals when each channel finishes. It sits between the channel register file (start/size) and the AXI4 read/write engine (grant/slice_done).

## Interface
- `C_NUM_CHANNELS`, 4: number of DMA channels, ≥2.
- `C_TRANSACTION_SIZE_WIDTH`, 32: width W of the size and remaining counters, in bytes.
- `C_FRAME_SIZE`, 256: maximum bytes per granted slice, ≥1, < 2^W.
- CW = C_LOG_2(C_NUM_CHANNELS)+1: channel index width, using the codebase log2 macro.

Ports:
- `ACLK` in 1: clock, rising edge.
- `ARESET` in 1: asynchronous reset, active-high.
- `ch_start` in N: per-channel arm pulse (one cycle).
- `ch_size` in N*W: channel i size at bits [i*W +: W]; sampled when `ch_start[i]` is high.
- `grant_valid` out 1: a slice is offered to the engine.
- `grant_ready` in 1: engine accepts the offered slice.
- `grant_channel` out CW: channel index of the offered or running slice.
- `grant_length` out W: bytes in the slice, = min(remaining, `C_FRAME_SIZE`).
- `slice_done` in 1: engine finished the running slice (one-cycle pulse).
- `ch_done` out N: one-cycle pulse when the channel's remaining count reaches 0.
- `ch_active` out N: channel's remaining count is ≠ 0.
- `busy` out 1: FSM is not in IDLE.

## Operation
- Per-channel register `rem[i]`, W bits.
  - `ch_start[i]` with `ch_size` ≠ 0 and `rem[i]` == 0 loads `rem[i]` ← size.
  - The start is ignored if `rem[i]` ≠ 0 or size == 0.
- `ch_active[i]` = (`rem[i]` ≠ 0). This is a registered value: it reflects a load in the cycle after the `ch_start`.
- Round-robin pointer `last` (CW bits): index of the last granted channel.
  - Next pick = first `i` with `ch_active[i]`, scanning `last`+1, `last`+2, … modulo `C_NUM_CHANNELS`, ending with `last` itself.
- FSM states:
  - **IDLE**: `grant_valid`=0. If any `ch_active` is set, go to ARB.
  - **ARB**: compute the pick and latch `grant_channel` and `grant_length`, then go to OFFER. If no channel is active, return to IDLE.
  - **OFFER**: `grant_valid`=1. `grant_channel` and `grant_length` are held stable until `grant_valid && grant_ready`. On that handshake, `last` ← `grant_channel` and the FSM goes to RUN.
  - **RUN**: `grant_valid`=0; waits for `slice_done`. On `slice_done`:
    - `rem[g]` ← `rem[g]` − `grant_length`.
    - If the result is 0, `ch_done[g]` pulses in the next cycle.
    - Go to ARB.
- `slice_done` outside RUN and `grant_ready` outside OFFER are ignored.
- A `ch_start` on the granted channel during OFFER or RUN is ignored, because `rem` ≠ 0.
- Subtraction never underflows, since `grant_length` ≤ `rem`.
- `ch_start[j]` in the same cycle as an update of a different channel g: both take effect.

## Timing
- Reset (asynchronous, any state) puts every output at 0:
  - `grant_valid`, `grant_channel`, `grant_length`, `ch_done`, `ch_active`, `busy` = 0.
  - All `rem` = 0, `last` = `C_NUM_CHANNELS`−1 (so the first pick starts at channel 0), FSM = IDLE.
  - A slice in flight at reset is abandoned; no `ch_done` pulse is generated.
- Start-to-grant latency: `ch_start` at cycle 0 gives `rem` loaded at 1, ARB at 2, and `grant_valid` high at 3.
- Slice turnaround: `slice_done` at cycle t gives `rem` update and `ch_done` at t+1 (ARB), and the next `grant_valid` at t+2.
- `busy` = 1 in ARB, OFFER and RUN.

## Test plan
- Single channel: ch0 start, size 600, `C_FRAME_SIZE`=256, engine always ready.
  - Expect slices (ch0, 256), (ch0, 256), (ch0, 88).
  - Expect a `ch_done[0]` pulse one cycle after the third `slice_done`, then IDLE with `busy`=0.
- Round robin: ch0 size 512 and ch2 size 300 armed together.
  - Expect grants in order (ch0, 256), (ch2, 256), (ch0, 256), (ch2, 44).
  - Expect `ch_done[0]` before `ch_done[2]`.
- Wrap-around: `last`=3, then ch3 and ch0 active.
  - Expect the next grant to go to ch0; ch3 must not be granted twice in a row.
- Backpressure: hold `grant_ready` low for 5 cycles in OFFER.
  - Expect `grant_valid`, `grant_channel` and `grant_length` stable for all 5 cycles.
  - Expect a single handshake when `grant_ready` rises.
- Ignored inputs:
  - `ch_start[1]` with size 1000 while `rem[1]`=100 leaves `rem[1]`=100.
  - `ch_start` with size 0 leaves `ch_active` at 0.
  - `slice_done` in IDLE changes nothing.
- Reset mid-operation: assert `ARESET` in RUN for ch1.
  - Expect all outputs 0 immediately and no `ch_done` pulse.
  - After release, a new ch1 start of size 10 gives grant (ch1, 10) at latency 3.
